// File: rtl/board_mem.sv
// rtl/board_mem.sv - 10x20 Tetris playfield storage with line-clear engine
//
// Purpose:
//   Holds the playfield as ROWS registers of COLS bits (row[y][x], y=0 top).
//   Serves two zero-latency read ports and one write port. On a clear_start
//   pulse it scans from the bottom row upward, removing every full row.
//   A removed row is dropped by shifting everything above it down one row.
//   It then reports how many rows it removed.
//
// Ports:
//   CLOCK_50       system clock
//   resetn         synchronous active-low reset
//   board_we       cell write enable (one cell per cycle, idle only)
//   board_wx/wy    write column/row
//   board_wdata    value written (1 = occupied)
//   board_rx/ry    game read column/row
//   board_rdata    occupancy at (board_rx, board_ry); 1 when out of range
//   vga_x/vga_y    painter read column/row
//   vga_cell       occupancy at (vga_x, vga_y); 0 when out of range
//   clear_start    1-cycle pulse starting a line-clear pass
//   clear_busy     high during scan/shift
//   clear_done     1-cycle pulse when the pass completes
//   lines_cleared  rows removed by the last completed pass

module board_mem #(
  parameter int COLS = 10,
  parameter int ROWS = 20
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       board_we,
  input  logic [3:0] board_wx,
  input  logic [4:0] board_wy,
  input  logic       board_wdata,
  input  logic [3:0] board_rx,
  input  logic [4:0] board_ry,
  output logic       board_rdata,
  input  logic [3:0] vga_x,
  input  logic [4:0] vga_y,
  output logic       vga_cell,
  input  logic       clear_start,
  output logic       clear_busy,
  output logic       clear_done,
  output logic [4:0] lines_cleared
);

  typedef enum logic [1:0] {
    C_IDLE,
    C_SCAN,
    C_SHIFT,
    C_DONE
  } state_t;

  localparam logic [3:0] X_LIM = 4'(COLS);
  localparam logic [4:0] Y_LIM = 5'(ROWS);
  localparam logic [4:0] R_TOP = 5'(ROWS - 1);

  state_t          state;
  state_t          state_next;
  logic [COLS-1:0] rows [ROWS];
  logic [4:0]      r;
  logic [4:0]      cnt;
  logic            row_full;
  logic            wr_ok;
  logic            game_in_range;
  logic            vga_in_range;

  // r never leaves 0..ROWS-1, so this index is always valid.
  assign row_full = &rows[r];

  assign wr_ok = board_we && (board_wx < X_LIM) && (board_wy < Y_LIM)
                 && (state == C_IDLE);

  // Out-of-range game reads return 1 so the piece logic sees walls and floor;
  // the painter just sees empty space.
  assign game_in_range = (board_rx < X_LIM) && (board_ry < Y_LIM);
  assign vga_in_range  = (vga_x < X_LIM) && (vga_y < Y_LIM);

  always_comb begin
    board_rdata = 1'b1;
    if (game_in_range) begin
      board_rdata = rows[board_ry][board_rx];
    end
  end

  always_comb begin
    vga_cell = 1'b0;
    if (vga_in_range) begin
      vga_cell = rows[vga_y][vga_x];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state <= C_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    clear_busy = 1'b0;
    clear_done = 1'b0;
    case (state)
      C_IDLE: begin
        if (clear_start) begin
          state_next = C_SCAN;
        end
      end
      C_SCAN: begin
        clear_busy = 1'b1;
        if (row_full) begin
          state_next = C_SHIFT;
        end else if (r == 5'd0) begin
          state_next = C_DONE;
        end
      end
      C_SHIFT: begin
        clear_busy = 1'b1;
        state_next = C_SCAN;
      end
      C_DONE: begin
        clear_done = 1'b1;
        state_next = C_IDLE;
      end
      default: begin
        state_next = C_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      for (logic [4:0] y = 5'd0; y < Y_LIM; y++) begin
        rows[y] <= '0;
      end
      r             <= 5'd0;
      cnt           <= 5'd0;
      lines_cleared <= 5'd0;
    end else begin
      case (state)
        C_IDLE: begin
          // A write alongside clear_start lands before the first scan cycle.
          if (wr_ok) begin
            rows[board_wy][board_wx] <= board_wdata;
          end
          if (clear_start) begin
            r   <= R_TOP;
            cnt <= 5'd0;
          end
        end
        C_SCAN: begin
          if (!row_full && (r != 5'd0)) begin
            r <= r - 5'd1;
          end
        end
        C_SHIFT: begin
          // Drop every row at or above r by one; r stays put so the row
          // that just fell into it gets scanned next.
          for (logic [4:0] y = 5'd1; y < Y_LIM; y++) begin
            if (y <= r) begin
              rows[y] <= rows[y - 5'd1];
            end
          end
          rows[0] <= '0;
          cnt     <= cnt + 5'd1;
        end
        C_DONE: begin
          lines_cleared <= cnt;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
